// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    XFER,
    CS_HOLD,
    BURST_WAIT
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period generator: toggles sck every CLK_DIV cycles while enabled,
// parks it at cpol otherwise, and flags leading/trailing edges one cycle ahead.
module spi_sck_gen #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpol,
  output logic sck,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick       = en && (cnt == CW'(CLK_DIV - 1));
  // sck still at its idle level means the coming toggle is the leading edge
  assign lead_edge  = tick && (sck == cpol);
  assign trail_edge = tick && (sck != cpol);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= cpol;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: DATA_W-bit words, run-time CPOL/CPHA, NUM_CS selects,
// CS-held bursts. Define SPI_LSB_FIRST_EN to add the lsb_first port.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 13,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              new_data,
  output logic [DATA_W-1:0] data_out
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  spi_state_e        state, state_nx;
  logic [PW-1:0]     ph_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              cpol_q, cpha_q, hold_q, lsb_q, lsb_nx;
  logic [CS_W-1:0]   cs_q, cs_nx;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next;
  logic              new_frame, accept, ph_last, done, tx_cpha;
  logic              lead_edge, trail_edge, shift_edge, sample_edge;
  logic              busy_d;
  logic [NUM_CS-1:0] cs_n_d;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_nx = lsb_first;
`else
  assign lsb_nx = 1'b0;
`endif

  function automatic logic tx_first(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  assign new_frame   = start && (state == IDLE);
  assign accept      = start && ((state == IDLE) || (state == BURST_WAIT));
  assign tx_cpha     = new_frame ? cpha : cpha_q;
  assign ph_last     = (ph_cnt == PW'(CLK_DIV - 1));
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign done        = trail_edge && (bit_cnt == BW'(DATA_W - 1));
  assign rx_next     = lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (state == XFER),
    .cpol       ((state == IDLE) ? cpol : cpol_q),
    .sck        (sck),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cs_n  <= '1;
    end else begin
      state <= state_nx;
      busy  <= busy_d;
      cs_n  <= cs_n_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start)   state_nx = CS_SETUP;
      CS_SETUP:   if (ph_last) state_nx = XFER;
      XFER:       if (done)    state_nx = hold_q ? BURST_WAIT : CS_HOLD;
      CS_HOLD:    if (ph_last) state_nx = IDLE;
      BURST_WAIT: if (start)   state_nx = XFER;
      default:                 state_nx = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it
  always_comb begin
    busy_d = (state_nx == CS_SETUP) || (state_nx == XFER) || (state_nx == CS_HOLD);
    cs_nx  = new_frame ? cs_sel : cs_q;
    cs_n_d = '1;
    if (state_nx != IDLE)
      for (int i = 0; i < NUM_CS; i++)
        if (cs_nx == CS_W'(i)) cs_n_d[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ph_cnt <= '0;
    else if (((state == CS_SETUP) || (state == CS_HOLD)) && (state_nx == state))
      ph_cnt <= ph_cnt + 1'b1;
    else ph_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi     <= 1'b0;
      new_data <= 1'b0;
      data_out <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hold_q   <= 1'b0;
      lsb_q    <= 1'b0;
      cs_q     <= '0;
    end else begin
      new_data <= done;
      // with cpha=1 the last bit is sampled on the very edge that ends the word
      if (done) data_out <= cpha_q ? rx_next : rx_sr;
      if (sample_edge) rx_sr <= rx_next;
      if (trail_edge) bit_cnt <= bit_cnt + 1'b1;
      if (accept) begin
        bit_cnt <= '0;
        hold_q  <= hold_cs;
        lsb_q   <= lsb_nx;
        if (new_frame) begin
          cpol_q <= cpol;
          cpha_q <= cpha;
          cs_q   <= cs_sel;
        end
        if (!tx_cpha) begin
          mosi  <= tx_first(data_in, lsb_nx);
          tx_sr <= tx_shift(data_in, lsb_nx);
        end else begin
          tx_sr <= data_in;
        end
      end else if (shift_edge) begin
        mosi  <= tx_first(tx_sr, lsb_q);
        tx_sr <= tx_shift(tx_sr, lsb_q);
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, CLK_DIV=2, NUM_CS=2) with a
// loopback / pattern slave on cs_n[0].
module tb_spi_master_param;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, cpol, cpha, cs_sel, hold_cs, miso;
  logic [7:0] data_in;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first;
`endif
  logic       mosi, sck, busy, new_data;
  logic [1:0] cs_n;
  logic [7:0] data_out;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .hold_cs(hold_cs),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n), .busy(busy),
    .new_data(new_data), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave on cs_n[0]: loopback, or shifts slv_pat out on its non-sampling edges
  logic       loop = 1'b1;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_pat = 8'h00;
  logic       sck_s = 1'b0, cs_s = 1'b1;
  int         sk = 0;
  assign miso = loop ? mosi : slv_miso;

  always @(cs_n or sck) begin
    if (cs_n[0]) begin
      sk = 0;
    end else if (cs_s) begin
      sk = 0;
      slv_miso = cpha ? 1'b0 : slv_pat[7];
    end else if (sck !== sck_s) begin
      if ((sck != cpol) == cpha) begin
        if (cpha) begin
          if (sk < 8) slv_miso = slv_pat[3'(7 - sk)];
          sk++;
        end else begin
          sk++;
          if (sk < 8) slv_miso = slv_pat[3'(7 - sk)];
        end
      end
    end
    cs_s  = cs_n[0];
    sck_s = sck;
  end

  // Cycle monitor sampled on the falling clock edge
  int   rises = 0, cs0_low = 0, cs1_hi = 0, viol = 0, nd_cnt = 0;
  logic sck_p = 1'b0, mosi_p = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (sck && !sck_p) rises++;
      if (!cs_n[0]) cs0_low++;
      if (cs_n[1]) cs1_hi++;
      if (new_data) nd_cnt++;
      if ((sck != sck_p) && (((sck != cpol) ^ cpha) == 1'b1) && (mosi != mosi_p)) viol++;
    end
    sck_p  = sck;
    mosi_p = mosi;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the accepting edge, i.e. observing cycle T0+1
  task automatic do_start(input logic [7:0] d, input logic h, input logic cs);
    @(negedge clk);
    data_in = d; hold_cs = h; cs_sel = cs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  logic [1:0] modes [4] = '{SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};
  int s0, s1, s2, s3;

  initial begin
    rst = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0;
    hold_cs = 1'b0; data_in = 8'h00;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    wait_cyc(3);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_new_data", new_data, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    @(negedge clk) rst = 1'b1;
    wait_cyc(2);

    // Single word, mode 0, loopback
    s0 = rises;
    do_start(8'hA5, 1'b0, 1'b0);
    s1 = cs0_low;
    chk("t1_busy_T1", busy, 1'b1);
    chk("t1_cs_n_T1", cs_n, 2'b10);
    chk("t1_mosi_msb", mosi, 1'b1);
    wait_cyc(33);
    chk("t1_nd_T34", new_data, 1'b0);
    wait_cyc(1);
    chk("t1_nd_T35", new_data, 1'b1);
    chk("t1_data_out", data_out, 8'hA5);
    wait_cyc(1);
    chk("t1_nd_T36", new_data, 1'b0);
    chk("t1_cs_n_T36", cs_n, 2'b10);
    chk("t1_busy_T36", busy, 1'b1);
    wait_cyc(1);
    chk("t1_cs_n_T37", cs_n, 2'b11);
    chk("t1_busy_T37", busy, 1'b0);
    chk("t1_cs0_low_cycles", cs0_low - s1, 36);
    chk("t1_sck_rises", rises - s0, 8);

    // All four modes against a slave sending 3C
    loop = 1'b0;
    slv_pat = 8'h3C;
    foreach (modes[m]) begin
      @(negedge clk) {cpol, cpha} = modes[m];
      wait_cyc(2);
      chk($sformatf("m%0d_idle_sck", m), sck, cpol);
      s0 = viol;
      do_start(8'h96, 1'b0, 1'b0);
      wait_cyc(34);
      chk($sformatf("m%0d_nd", m), new_data, 1'b1);
      chk($sformatf("m%0d_data_out", m), data_out, 8'h3C);
      wait_cyc(2);
      chk($sformatf("m%0d_mosi_on_sample_edge", m), viol - s0, 0);
      chk($sformatf("m%0d_sck_end", m), sck, cpol);
      chk($sformatf("m%0d_busy_end", m), busy, 1'b0);
    end
    loop = 1'b1;
    @(negedge clk) {cpol, cpha} = SPI_MODE0;
    wait_cyc(2);

    // Burst on cs 1: 11 with hold, then 22 (cs_sel=0 must not be re-latched)
    s2 = nd_cnt;
    do_start(8'h11, 1'b1, 1'b1);
    s0 = cs0_low; s1 = cs1_hi;
    chk("b_cs_n_T1", cs_n, 2'b01);
    wait_cyc(34);
    chk("b_nd1", new_data, 1'b1);
    chk("b_data1", data_out, 8'h11);
    chk("b_busy_wait", busy, 1'b0);
    chk("b_cs_n_wait", cs_n, 2'b01);
    wait_cyc(2);
    chk("b_cs_n_wait2", cs_n, 2'b01);
    do_start(8'h22, 1'b0, 1'b0);
    chk("b_busy2", busy, 1'b1);
    chk("b_cs_n2", cs_n, 2'b01);
    wait_cyc(31);
    chk("b_nd2_early", new_data, 1'b0);
    wait_cyc(1);
    chk("b_nd2", new_data, 1'b1);
    chk("b_data2", data_out, 8'h22);
    wait_cyc(1);
    chk("b_cs_n_hold", cs_n, 2'b01);
    chk("b_cs1_high_cycles", cs1_hi - s1, 0);
    chk("b_cs0_low_cycles", cs0_low - s0, 0);
    chk("b_nd_pulses", nd_cnt - s2, 2);
    wait_cyc(1);
    chk("b_cs_n_end", cs_n, 2'b11);
    chk("b_busy_end", busy, 1'b0);

    // Start while busy is ignored
    s2 = nd_cnt;
    do_start(8'hC3, 1'b0, 1'b0);
    wait_cyc(9);
    @(negedge clk);
    data_in = 8'hFF; cs_sel = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("sb_cs_n", cs_n, 2'b10);
    wait_cyc(24);
    chk("sb_nd", new_data, 1'b1);
    chk("sb_data", data_out, 8'hC3);
    wait_cyc(5);
    chk("sb_busy", busy, 1'b0);
    chk("sb_nd_pulses", nd_cnt - s2, 1);
    chk("sb_cs_n_end", cs_n, 2'b11);

    // Start held during reset and dropped at release
    s0 = cs0_low;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; cs_sel = 1'b0; data_in = 8'hFF;
    wait_cyc(2);
    chk("rs_busy_in_rst", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    wait_cyc(3);
    chk("rs_busy", busy, 1'b0);
    chk("rs_cs_n", cs_n, 2'b11);
    chk("rs_sck", sck, 1'b0);
    chk("rs_cs0_low_cycles", cs0_low - s0, 0);

    // Asynchronous reset at SCK edge 5, then a clean frame
    do_start(8'h96, 1'b0, 1'b0);
    wait_cyc(12);
    chk("ar_sck_edge5", sck, 1'b1);
    rst = 1'b0;
    #1;
    chk("ar_sck", sck, 1'b0);
    chk("ar_mosi", mosi, 1'b0);
    chk("ar_cs_n", cs_n, 2'b11);
    chk("ar_busy", busy, 1'b0);
    chk("ar_data_out", data_out, 8'h00);
    chk("ar_nd", new_data, 1'b0);
    wait_cyc(2);
    @(negedge clk) rst = 1'b1;
    wait_cyc(1);
    do_start(8'h5A, 1'b0, 1'b0);
    chk("ar2_cs_n", cs_n, 2'b10);
    wait_cyc(34);
    chk("ar2_nd", new_data, 1'b1);
    chk("ar2_data", data_out, 8'h5A);
    wait_cyc(2);
    chk("ar2_busy", busy, 1'b0);

`ifdef SPI_LSB_FIRST_EN
    @(negedge clk) lsb_first = 1'b1;
    do_start(8'h01, 1'b0, 1'b0);
    chk("lsb_mosi_first", mosi, 1'b1);
    wait_cyc(34);
    chk("lsb_nd", new_data, 1'b1);
    chk("lsb_data", data_out, 8'h01);
    wait_cyc(2);
    @(negedge clk) lsb_first = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised successor to the fixed 8-bit, mode-0 spi_master used in the SPI test top level. Runs full-duplex SPI transfers of DATA_W bits with a run-time CPOL/CPHA mode, an internal SCK divider, NUM_CS chip selects and optional CS-held bursts. It sits between a command source (test-constant generator or sensor sequencer) and the off-board SPI peripherals, clocked from the PLL global clock.

Parameters:
DATA_W, 8, bits per word; legal range 2 to 32.
CLK_DIV, 13, clk cycles per SCK half-period. Minimum 1. 26 MHz / (2*13) gives a 1 MHz SCK.
NUM_CS, 1, number of chip-select outputs. Minimum 1.
CS_W, $clog2(NUM_CS) with a minimum of 1, width of cs_sel. Derived; not overridden.

Ports:
clk  in  1  system clock (PLL GLA)
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; sampled only while busy=0
data_in  in  DATA_W  word to transmit; latched on accepted start
cpol  in  1  SCK idle level; latched on accepted start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accepted start
cs_sel  in  CS_W  chip-select index; latched on start of a new frame
hold_cs  in  1  keep CS asserted after this word (burst); latched on start
miso  in  1  serial input
mosi  out  1  serial output
sck  out  1  SPI clock
cs_n  out  NUM_CS  active-low chip selects
busy  out  1  transfer in progress
new_data  out  1  one-cycle pulse when data_out is valid
data_out  out  DATA_W  received word

Behaviour:
- Reset values: sck=0, mosi=0, cs_n=all 1, busy=0, new_data=0, data_out=0, state=IDLE, latched cpol=0. Reset is asynchronous: mid-transfer it aborts the frame and forces these values immediately.
- Reset polarity and synchronicity are fixed: one clock, asynchronous active-low reset.
- States:
  - IDLE: cs_n deasserted; sck follows cpol input registered each cycle.
  - CS_SETUP: CLK_DIV cycles with CS low.
  - XFER: 2*DATA_W half-periods of CLK_DIV cycles each.
  - CS_HOLD: CLK_DIV cycles with CS still low.
  - BURST_WAIT: CS low, busy=0, sck at CPOL.
- Accepting start, cycle T0:
  - IDLE -> CS_SETUP at T0+1; busy=1 and selected cs_n low from T0+1.
  - The MSB appears on mosi at T0+1 when cpha=0. When cpha=1 it appears at the first SCK edge.
- SCK toggles at each half-period end in XFER. Sampling: miso is sampled on edges where (edge is leading) XOR cpha. The shift register is updated on the opposite edge.
- new_data and data_out: new_data pulses at T0+1+CLK_DIV*(1+2*DATA_W), and data_out updates in the same cycle.
- End of word:
  - hold_cs=0: go to CS_HOLD, then IDLE. busy falls on entry to IDLE.
  - hold_cs=1: go to BURST_WAIT, busy=0.
- BURST_WAIT:
  - A start there goes directly to XFER on the next cycle, with no CS_SETUP.
  - cpol, cpha and cs_sel are not re-latched in BURST_WAIT. data_in and hold_cs are latched.
- busy, sck and cs_n are registered, with no combinational path from inputs.
- start while busy=1 is ignored with no side effects.
- start and reset asserted together: reset wins.
- cs_sel >= NUM_CS: the transfer runs, but no cs_n line asserts.
- CLK_DIV=1: SCK = clk/2 with no idle cycles between half-periods.

Optional Feature:
SPI_LSB_FIRST_EN:
- Defined: adds input port lsb_first (1 bit, latched on start). When 1, both transmit and receive are LSB-first.
- Undefined: the port is absent and transfers are always MSB-first.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, CS_SETUP, XFER, CS_HOLD, BURST_WAIT)
  - mode constants SPI_MODE0..3
  - a function for CS_W derivation
- One sub-module, spi_sck_gen: half-period counter emitting lead_edge and trail_edge strobes plus sck, with enable and cpol inputs.

Test Plan:
- Reset then single word, DATA_W=8, CLK_DIV=2, mode 0, data_in=8'hA5, miso looped to mosi:
  - new_data at T0+35 with data_out=8'hA5.
  - 8 rising SCK edges.
  - cs_n[0] low from T0+1 to T0+37.
- Modes 1/2/3 with slave model sending 8'h3C:
  - sck idles at cpol.
  - data_out=8'h3C in every mode.
  - mosi changes only on non-sampling edges.
- Burst, hold_cs=1 then 0, words 8'h11, 8'h22, NUM_CS=2, cs_sel=1:
  - cs_n[1] stays low across both words.
  - cs_n[0] stays high.
  - two new_data pulses.
- start while busy and start in the same cycle as reset release:
  - no restart and no glitch on sck or cs_n.
  - reset-held start is ignored.
- Reset asserted in mid XFER (edge 5):
  - outputs take reset values asynchronously.
  - the next start runs a clean full frame.
- SPI_LSB_FIRST_EN defined, lsb_first=1, data_in=8'h01:
  - mosi emits 1 first.
  - loopback data_out=8'h01.
